// File: rtl/loader_word_packer.sv
// loader_word_packer: merges 8/16-bit loader writes into 32-bit words with byte enables and queues them for the memory controller.
// Optional LOADER_PACKER_TIMEOUT_EN pushes a partial word after 255 idle cycles.
module loader_word_packer #(
    parameter int ADDR_WIDTH      = 25,
    parameter int INPUT_WORD_SIZE = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                         clk_memory,
    input  logic                         reset_n,
    input  logic                         in_wr_en,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [8*INPUT_WORD_SIZE-1:0] in_data,
    input  logic                         in_flush,
    output logic                         mem_req,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [31:0]                  mem_data,
    output logic [3:0]                   mem_be,
    input  logic                         mem_ack,
    output logic                         overflow,
    output logic                         busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [1:0] LMASK = (INPUT_WORD_SIZE == 2) ? 2'b10 : 2'b11;
    localparam logic [3:0] BE0   = (INPUT_WORD_SIZE == 2) ? 4'h3 : 4'h1;

    if (INPUT_WORD_SIZE != 1 && INPUT_WORD_SIZE != 2) begin : g_bad_iws
        $error("loader_word_packer: INPUT_WORD_SIZE must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("loader_word_packer: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic          prev_wr_q, flush_pend_q, flush_pend_d;
    logic          pack_valid_q, pack_valid_d, overflow_q, overflow_d;
    logic [WW-1:0] pack_addr_q, pack_addr_d;
    logic [31:0]   pack_data_q, pack_data_d;
    logic [3:0]    pack_be_q, pack_be_d;
    logic [PW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WW-1:0] fifo_addr [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [3:0]    fifo_be   [FIFO_DEPTH];

    logic [1:0]    lane;
    logic [3:0]    be_w, mrg_be, push_be;
    logic [31:0]   data_w, mask_w, mrg_data, push_data;
    logic [WW-1:0] push_addr;
    logic          accept, hit, push, push_ok, pop, full, empty, tmo;

    assign lane     = in_addr[1:0] & LMASK;
    assign be_w     = BE0 << lane;
    assign data_w   = 32'(in_data) << {lane, 3'b000};
    assign mask_w   = {{8{be_w[3]}}, {8{be_w[2]}}, {8{be_w[1]}}, {8{be_w[0]}}};
    assign mrg_data = (pack_data_q & ~mask_w) | data_w;
    assign mrg_be   = pack_be_q | be_w;
    assign accept   = in_wr_en & ~prev_wr_q;
    assign hit      = pack_valid_q && pack_addr_q == in_addr[ADDR_WIDTH-1:2];
    assign empty    = wr_ptr_q == rd_ptr_q;
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop      = mem_ack & ~empty;

`ifdef LOADER_PACKER_TIMEOUT_EN
    logic [7:0] idle_q, idle_d;
    assign tmo    = pack_valid_q && idle_q == 8'hFF;
    assign idle_d = accept ? 8'd0 : pack_valid_q ? idle_q + 8'd1 : 8'd0;
    always_ff @(posedge clk_memory or negedge reset_n)
        if (!reset_n) idle_q <= '0;
        else          idle_q <= idle_d;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        pack_valid_d = pack_valid_q;
        pack_addr_d  = pack_addr_q;
        pack_data_d  = pack_data_q;
        pack_be_d    = pack_be_q;
        flush_pend_d = 1'b0;
        push         = 1'b0;
        push_addr    = pack_addr_q;
        push_data    = pack_data_q;
        push_be      = pack_be_q;
        if (accept) begin
            // a flush arriving with the write runs next cycle, after the merge
            flush_pend_d = in_flush;
            if (hit) begin
                push         = mrg_be == 4'hF;
                pack_valid_d = mrg_be != 4'hF;
                pack_data_d  = mrg_data;
                pack_be_d    = mrg_be;
                push_data    = mrg_data;
                push_be      = mrg_be;
            end else begin
                push         = pack_valid_q;
                pack_valid_d = 1'b1;
                pack_addr_d  = in_addr[ADDR_WIDTH-1:2];
                pack_data_d  = data_w;
                pack_be_d    = be_w;
            end
        end else if (pack_valid_q && (in_flush || flush_pend_q || tmo)) begin
            push         = 1'b1;
            pack_valid_d = 1'b0;
        end
    end

    assign push_ok    = push & (~full | pop);
    assign overflow_d = overflow_q | (push & full & ~pop);
    assign wr_ptr_d   = wr_ptr_q + (PW+1)'(push_ok);
    assign rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);

    always_ff @(posedge clk_memory or negedge reset_n)
        if (!reset_n) begin
            prev_wr_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            pack_valid_q <= 1'b0;
            pack_addr_q  <= '0;
            pack_data_q  <= '0;
            pack_be_q    <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            prev_wr_q    <= in_wr_en;
            flush_pend_q <= flush_pend_d;
            pack_valid_q <= pack_valid_d;
            pack_addr_q  <= pack_addr_d;
            pack_data_q  <= pack_data_d;
            pack_be_q    <= pack_be_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end

    always_ff @(posedge clk_memory)
        if (push_ok) begin
            fifo_addr[wr_ptr_q[PW-1:0]] <= push_addr;
            fifo_data[wr_ptr_q[PW-1:0]] <= push_data;
            fifo_be[wr_ptr_q[PW-1:0]]   <= push_be;
        end

    // head fields are gated so the outputs read zero whenever nothing is queued
    assign mem_req  = ~empty;
    assign mem_addr = mem_req ? {fifo_addr[rd_ptr_q[PW-1:0]], 2'b00} : '0;
    assign mem_data = mem_req ? fifo_data[rd_ptr_q[PW-1:0]] : '0;
    assign mem_be   = mem_req ? fifo_be[rd_ptr_q[PW-1:0]] : '0;
    assign overflow = overflow_q;
    assign busy     = pack_valid_q | ~empty | flush_pend_q;
endmodule
